vlc_tx_frame_scheduler: RTL

//  Frame-level controller for the VLC transmitter. Arbitrates two frame sources (data, beacon) round-robin.

---
 rtl/vlc_tx_pkg.sv | 25 ++
 rtl/vlc_tx_frame_scheduler_if.sv | 30 +++
 rtl/sym_tick_gen.sv | 23 ++
 rtl/vlc_tx_frame_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vlc_tx_pkg.sv
// rtl/vlc_tx_pkg.sv - shared encodings and constants for the VLC transmit frame scheduler
package vlc_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_GUARD
  } state_e;

  localparam int HDR_W = 8;

  // Indexed by symbol parity: even symbols carry 1, odd symbols carry 0.
  localparam logic [1:0] PREAMBLE_PAT = 2'b01;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/vlc_tx_frame_scheduler_if.sv
// rtl/vlc_tx_frame_scheduler_if.sv - source arbitration, byte feed and LED-side signals of the scheduler
interface vlc_tx_frame_scheduler_if;
  logic       req_data;
  logic [7:0] len_data;
  logic       req_beacon;
  logic [7:0] len_beacon;
  logic       grant_data;
  logic       grant_beacon;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       sym_tick;
  logic       tx_bit;
  logic       tx_en;
  logic       tx_complete;
  logic       tx_err;
  logic       busy;

  modport master (
    output req_data, len_data, req_beacon, len_beacon, byte_in, byte_valid,
    input  grant_data, grant_beacon, byte_ready, sym_tick, tx_bit, tx_en,
           tx_complete, tx_err, busy
  );

  modport slave (
    input  req_data, len_data, req_beacon, len_beacon, byte_in, byte_valid,
    output grant_data, grant_beacon, byte_ready, sym_tick, tx_bit, tx_en,
           tx_complete, tx_err, busy
  );
endinterface

// File: rtl/sym_tick_gen.sv
// rtl/sym_tick_gen.sv - free-running symbol-rate divider, one-cycle tick every DIV_FREQ clocks
module sym_tick_gen #(
  parameter int DIV_FREQ = 25
) (
  input  logic clk,
  input  logic rst_n,
  output logic sym_tick_o
);
  localparam int CW = $clog2(DIV_FREQ);

  logic [CW-1:0] count_q, count_d;

  assign sym_tick_o = (count_q == CW'(DIV_FREQ - 1));

  always_comb begin
    count_d = sym_tick_o ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/vlc_tx_frame_scheduler.sv
// rtl/vlc_tx_frame_scheduler.sv - round-robin frame arbiter and PREAMBLE/HEADER/PAYLOAD/GUARD sequencer
module vlc_tx_frame_scheduler
  import vlc_tx_pkg::*;
#(
  parameter int DIV_FREQ     = 25,
  parameter int PREAMBLE_LEN = 16,
  parameter int GUARD_LEN    = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  vlc_tx_frame_scheduler_if.slave bus
);
  localparam int CNT_W = cnt_width(PREAMBLE_LEN, GUARD_LEN, HDR_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [7:0]       len_q, len_d, fetched_q, fetched_d, sent_q, sent_d;
  logic [7:0]       hold_q, hold_d, shift_q, shift_d;
  logic             hold_full_q, hold_full_d;
  logic             gnt_data_q, gnt_data_d, gnt_beacon_q, gnt_beacon_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;
  logic             tx_bit_q, tx_bit_d, tx_en_q, tx_en_d;
  logic             tx_complete_q, tx_complete_d, tx_err_q, tx_err_d;

  logic sym_tick, in_hp, sym_last, underrun_tick, byte_ready, byte_xfer, win_beacon;

  sym_tick_gen #(.DIV_FREQ(DIV_FREQ)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_tick_o(sym_tick)
  );

  // rr_q = 0 prefers data, 1 prefers beacon; only consulted when both request.
  assign win_beacon    = bus.req_beacon & (~bus.req_data | rr_q);
  assign in_hp         = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
  assign sym_last      = (sym_cnt_q == CNT_W'(HDR_W));
  assign underrun_tick = sym_tick & in_hp & sym_last & (sent_q != len_q) & ~hold_full_q;
  assign byte_ready    = (gnt_data_q | gnt_beacon_q) & ~hold_full_q & in_hp
                         & (fetched_q < len_q) & ~underrun_tick;
  assign byte_xfer     = bus.byte_valid & byte_ready;

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    len_d         = len_q;
    fetched_d     = fetched_q;
    sent_d        = sent_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    gnt_data_d    = gnt_data_q;
    gnt_beacon_d  = gnt_beacon_q;
    rr_d          = rr_q;
    err_d         = err_q;
    tx_bit_d      = tx_bit_q;
    tx_en_d       = tx_en_q;
    tx_complete_d = 1'b0;
    tx_err_d      = 1'b0;

    if (byte_xfer) begin
      hold_d      = bus.byte_in;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 8'd1;
    end

    if (sym_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_data | bus.req_beacon) begin
            gnt_beacon_d = win_beacon;
            gnt_data_d   = ~win_beacon;
            rr_d         = ~win_beacon;
            len_d        = win_beacon ? bus.len_beacon : bus.len_data;
            fetched_d    = '0;
            sent_d       = '0;
            hold_full_d  = 1'b0;
            err_d        = 1'b0;
            state_d      = ST_PREAMBLE;
            sym_cnt_d    = CNT_W'(1);
            tx_bit_d     = PREAMBLE_PAT[0];
            tx_en_d      = 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (sym_cnt_q == CNT_W'(PREAMBLE_LEN)) begin
            state_d   = ST_HEADER;
            sym_cnt_d = CNT_W'(1);
            tx_bit_d  = len_q[7];
            shift_d   = {len_q[6:0], 1'b0};
          end else begin
            tx_bit_d  = PREAMBLE_PAT[sym_cnt_q[0]];
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          if (sym_last) begin
            // Byte boundary: finish, load the next byte, or abort on an empty holding reg.
            sym_cnt_d = CNT_W'(1);
            if (sent_q == len_q) begin
              state_d  = ST_GUARD;
              tx_bit_d = 1'b0;
              tx_en_d  = 1'b0;
            end else if (hold_full_q) begin
              state_d     = ST_PAYLOAD;
              tx_bit_d    = hold_q[7];
              shift_d     = {hold_q[6:0], 1'b0};
              hold_full_d = 1'b0;
              sent_d      = sent_q + 8'd1;
            end else begin
              state_d  = ST_GUARD;
              tx_bit_d = 1'b0;
              tx_en_d  = 1'b0;
              err_d    = 1'b1;
            end
          end else begin
            tx_bit_d  = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
        ST_GUARD: begin
          if (sym_cnt_q == CNT_W'(GUARD_LEN)) begin
            state_d       = ST_IDLE;
            sym_cnt_d     = '0;
            gnt_data_d    = 1'b0;
            gnt_beacon_d  = 1'b0;
            tx_complete_d = 1'b1;
            tx_err_d      = err_q;
            err_d         = 1'b0;
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sym_cnt_q     <= '0;
      len_q         <= '0;
      fetched_q     <= '0;
      sent_q        <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      gnt_data_q    <= 1'b0;
      gnt_beacon_q  <= 1'b0;
      rr_q          <= 1'b0;
      err_q         <= 1'b0;
      tx_bit_q      <= 1'b0;
      tx_en_q       <= 1'b0;
      tx_complete_q <= 1'b0;
      tx_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_cnt_q     <= sym_cnt_d;
      len_q         <= len_d;
      fetched_q     <= fetched_d;
      sent_q        <= sent_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      gnt_data_q    <= gnt_data_d;
      gnt_beacon_q  <= gnt_beacon_d;
      rr_q          <= rr_d;
      err_q         <= err_d;
      tx_bit_q      <= tx_bit_d;
      tx_en_q       <= tx_en_d;
      tx_complete_q <= tx_complete_d;
      tx_err_q      <= tx_err_d;
    end
  end

  assign bus.grant_data   = gnt_data_q;
  assign bus.grant_beacon = gnt_beacon_q;
  assign bus.byte_ready   = byte_ready;
  assign bus.sym_tick     = sym_tick;
  assign bus.tx_bit       = tx_bit_q;
  assign bus.tx_en        = tx_en_q;
  assign bus.tx_complete  = tx_complete_q;
  assign bus.tx_err       = tx_err_q;
  assign bus.busy         = (state_q != ST_IDLE);
endmodule
